// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and operand-A select for the sequential ALU
package alu_seq_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
  typedef enum logic [1:0] {ASEL_PASS, ASEL_CLR_MSB, ASEL_CLR_LSB, ASEL_AND} asel_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Operands arrive zero-extended to MAX_W; w is the live operand width.
  function automatic logic [MAX_W-1:0] sel_a(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input asel_e            asel,
                                             input int               w);
    logic [MAX_W-1:0] msb;
    msb = MAX_W'(1) << (w - 1);
    case (asel)
      ASEL_PASS:    sel_a = a;
      ASEL_CLR_MSB: sel_a = a & ~msb;
      ASEL_CLR_LSB: sel_a = a & ~MAX_W'(1);
      ASEL_AND:     sel_a = a & b;
      default:      sel_a = a;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - iterative shift-add multiply / restoring divide, MSB first
// done marks the final step cycle; result carries that step's value.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_div,
  input  logic [WIDTH-1:0]   a_op,
  input  logic [WIDTH-1:0]   b_op,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW = 2 * WIDTH;

  logic [WIDTH-1:0] a_r, b_r;
  logic             div_r;
  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [RW-1:0]    acc, acc_next;
  logic [WIDTH-1:0] rem, rem_next;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;

  // Restoring step: a negative trial difference means the divisor did not fit.
  always_comb begin
    shifted  = {rem, a_r[cnt]};
    diff     = shifted - {1'b0, b_r};
    fits     = ~diff[WIDTH];
    rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    if (div_r)
      acc_next = (acc << 1) | RW'(fits);
    else
      acc_next = (acc << 1) + (b_r[cnt] ? RW'(a_r) : '0);
  end

  assign done   = busy && (cnt == '0);
  assign result = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      div_r <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      rem   <= '0;
    end else if (start) begin
      a_r   <= a_op;
      b_r   <= b_op;
      div_r <= op_div;
      busy  <= 1'b1;
      cnt   <= CNT_W'(WIDTH - 1);
      acc   <= '0;
      rem   <= '0;
    end else if (busy) begin
      acc <= acc_next;
      rem <= rem_next;
      cnt <= cnt - 1'b1;
      if (cnt == '0)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU: FSM, add/sub path, divide-by-zero
// Optional div0 output port under ALU_SEQ_DIV0_FLAG_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         control,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
`ifdef ALU_SEQ_DIV0_FLAG_EN
  ,
  output logic               div0
`endif
);

  localparam int RW = 2 * WIDTH;

  state_e           state, state_nxt;
  op_e              op;
  logic             accept, b_zero, iter_start, iter_done;
  logic [MAX_W-1:0] a_sel_full;
  logic [WIDTH-1:0] a_sel;
  logic [RW-1:0]    iter_result;
  logic             unused_sel_hi;

  assign op            = op_e'(control[3:2]);
  assign a_sel_full    = sel_a(MAX_W'(a), MAX_W'(b), asel_e'(control[1:0]), WIDTH);
  assign a_sel         = a_sel_full[WIDTH-1:0];
  assign unused_sel_hi = ^a_sel_full[MAX_W-1:WIDTH];
  assign b_zero        = (b == '0);

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  // Divide by zero skips the iterator and answers all-ones immediately.
  assign iter_start = accept && ((op == OP_MUL) || ((op == OP_DIV) && !b_zero));

  alu_seq_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .op_div (op == OP_DIV),
    .a_op   (a_sel),
    .b_op   (b),
    .done   (iter_done),
    .result (iter_result)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = iter_start ? CALC : DONE;
      CALC: if (iter_done) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (accept && !iter_start) begin
      case (op)
        OP_ADD:  out <= RW'(a_sel) + RW'(b);
        OP_SUB:  out <= RW'(a_sel) - RW'(b);
        default: out <= '1;
      endcase
    end else if ((state == CALC) && iter_done) begin
      out <= iter_result;
    end
  end

`ifdef ALU_SEQ_DIV0_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)
      div0 <= 1'b0;
    else if (accept)
      div0 <= (op == OP_DIV) && b_zero;
    else if (out_valid && out_ready)
      div0 <= 1'b0;
  end
`endif

endmodule
